iomem_fabric: RTL

Parametrised iomem interconnect between the picosoc iomem master port and up to NUM_SLAVES memory-mapped peripherals (gpio, simplerng, user_ram, future blocks). It decodes a slot index from the address and holds a registered, one-hot slave select until the slave responds. The fabric also enforces a per-access timeout and answers unmapped or timed-out accesses with an error word. It records the first error (sticky flag plus faulting address) for firmware diagnosis.

---
 rtl/iomem_pkg.sv | 15 +
 rtl/iomem_decode.sv | 33 +++
 rtl/iomem_fabric.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/iomem_pkg.sv
// Shared constants for the picosoc iomem fabric: FSM encoding, default error word
// and the fixed slot map used by firmware and peripheral wrappers.
package iomem_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam int SLOT_GPIO = 0;
  localparam int SLOT_RNG  = 1;
  localparam int SLOT_RAM  = 2;

endpackage

// File: rtl/iomem_decode.sv
// Combinational iomem address decoder: window match plus slot index, also
// produced as a one-hot select vector for the populated slots.
module iomem_decode #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          SLOT_LSB   = 12,
  parameter int          SLOT_W     = 4
) (
  input  logic [31-SLOT_LSB:0]  addr_hi,
  output logic                  mapped,
  output logic [SLOT_W-1:0]     idx,
  output logic [NUM_SLAVES-1:0] onehot
);

  localparam int HI_W = 32 - SLOT_LSB - SLOT_W;
  localparam logic [HI_W-1:0] BASE_HI = BASE_ADDR[31 -: HI_W];

  logic base_hit;
  logic idx_ok;

  assign idx      = addr_hi[SLOT_W-1:0];
  assign base_hit = (addr_hi[31-SLOT_LSB -: HI_W] == BASE_HI);
  assign idx_ok   = (32'(idx) < 32'(NUM_SLAVES));
  assign mapped   = base_hit && idx_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_onehot
      assign onehot[gi] = base_hit && (idx == SLOT_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/iomem_fabric.sv
// iomem interconnect: registered one-hot slave select, per-access timeout and
// error-word response, with first-error capture for firmware diagnosis.
module iomem_fabric
  import iomem_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          SLOT_LSB   = 12,
  parameter int          SLOT_W     = 4,
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic [31:0]              iomem_rdata,
  output logic [NUM_SLAVES-1:0]    slv_sel,
  output logic [3:0]               slv_wstrb,
  output logic [31:0]              slv_addr,
  output logic [31:0]              slv_wdata,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  input  logic [32*NUM_SLAVES-1:0] slv_rdata,
  output logic                     err_flag,
  output logic [31:0]              err_addr,
  input  logic                     err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  ready_reg, ready_next;
  logic [31:0]           rdata_reg, rdata_next;
  logic [NUM_SLAVES-1:0] sel_reg, sel_next;
  logic [3:0]            wstrb_reg, wstrb_next;
  logic [31:0]           addr_reg, addr_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic                  err_flag_reg, err_flag_next;
  logic [31:0]           err_addr_reg, err_addr_next;

  logic                  dec_mapped;
  logic [SLOT_W-1:0]     dec_idx;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  err_event;
  logic [31:0]           err_event_addr;

  iomem_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .SLOT_LSB   (SLOT_LSB),
    .SLOT_W     (SLOT_W)
  ) u_decode (
    .addr_hi (iomem_addr[31:SLOT_LSB]),
    .mapped  (dec_mapped),
    .idx     (dec_idx),
    .onehot  (dec_onehot)
  );

  // The one-hot select gates both ready and read data, so only the slave that
  // owns the access can complete it.
  logic [31:0] rdata_slot [NUM_SLAVES];
  logic [31:0] sel_rdata;
  logic        sel_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
      assign rdata_slot[gi] = sel_reg[gi] ? slv_rdata[32*gi +: 32] : 32'd0;
    end
  endgenerate

  always_comb begin
    sel_rdata = 32'd0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_rdata = sel_rdata | rdata_slot[i];
    end
  end

  assign sel_ready = |(sel_reg & slv_ready);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ready_next     = ready_reg;
    rdata_next     = rdata_reg;
    sel_next       = sel_reg;
    wstrb_next     = wstrb_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    err_event      = 1'b0;
    err_event_addr = addr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (iomem_valid) begin
          addr_next  = iomem_addr;
          wdata_next = iomem_wdata;
          cnt_next   = '0;
          if (dec_mapped) begin
            sel_next   = dec_onehot;
            wstrb_next = iomem_wstrb;
            state_next = ST_ACCESS;
          end else begin
            sel_next       = '0;
            wstrb_next     = 4'd0;
            rdata_next     = ERR_DATA;
            ready_next     = 1'b1;
            state_next     = ST_RESP;
            err_event      = 1'b1;
            err_event_addr = iomem_addr;
          end
        end
      end
      ST_ACCESS: begin
        cnt_next = cnt_reg + 1'b1;
        // Ready is tested first so a response on the timeout cycle still wins.
        if (sel_ready) begin
          rdata_next = sel_rdata;
          sel_next   = '0;
          wstrb_next = 4'd0;
          ready_next = 1'b1;
          state_next = ST_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          rdata_next = ERR_DATA;
          sel_next   = '0;
          wstrb_next = 4'd0;
          ready_next = 1'b1;
          state_next = ST_RESP;
          err_event  = 1'b1;
        end
      end
      ST_RESP: begin
        ready_next = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        ready_next = 1'b0;
        sel_next   = '0;
        wstrb_next = 4'd0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    err_flag_next = err_flag_reg;
    err_addr_next = err_addr_reg;
    if (err_event) begin
      err_flag_next = 1'b1;
      if (!err_flag_reg || err_clr) begin
        err_addr_next = err_event_addr;
      end
    end else if (err_clr) begin
      err_flag_next = 1'b0;
      err_addr_next = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      ready_reg    <= 1'b0;
      rdata_reg    <= 32'd0;
      sel_reg      <= '0;
      wstrb_reg    <= 4'd0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      err_flag_reg <= 1'b0;
      err_addr_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ready_reg    <= ready_next;
      rdata_reg    <= rdata_next;
      sel_reg      <= sel_next;
      wstrb_reg    <= wstrb_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      err_flag_reg <= err_flag_next;
      err_addr_reg <= err_addr_next;
    end
  end

  assign iomem_ready = ready_reg;
  assign iomem_rdata = rdata_reg;
  assign slv_sel     = sel_reg;
  assign slv_wstrb   = wstrb_reg;
  assign slv_addr    = addr_reg;
  assign slv_wdata   = wdata_reg;
  assign err_flag    = err_flag_reg;
  assign err_addr    = err_addr_reg;

endmodule
